id_ex_skid_reg: RTL and testbench
=================================

ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 Parameter WORD_WIDTH, default 32, width of pc, instruction, val_Rn, val_Rm.
REQ-002 Parameter CTRL_WIDTH, default 40, width of packed control bundle (dst, imm, shifter operand, EX_command, status, mem/WB/Imm/B/SR flags).
REQ-003 Parameter CNT_WIDTH, default 16, width of stall counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  discard all held entries (branch taken).
REQ-007 in_valid  in  1  ID stage presents an instruction.
REQ-008 in_ready  out  1  stage can accept this cycle.
REQ-009 pc_in, instruction_in, val_Rn_in, val_Rm_in  in  WORD_WIDTH each  ID payload.
REQ-010 ctrl_in  in  CTRL_WIDTH  ID control bundle.
REQ-011 out_valid  out  1  head entry valid for EX.
REQ-012 out_ready  in  1  EX consumes head this cycle.
REQ-013 pc, instruction, val_Rn_out, val_Rm_out  out  WORD_WIDTH each  head payload.
REQ-014 ctrl_out  out  CTRL_WIDTH  head control bundle.
REQ-015 occupancy  out  2  entries held (0..2).
REQ-016 stall_cycles  out  CNT_WIDTH  saturating count of back-pressure cycles.

Function
REQ-017 Stage SHALL be a two-entry skid buffer with states EMPTY, ONE, FULL; occupancy SHALL equal 0/1/2 respectively.
REQ-018 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, derived from state only (no combinational path from out_ready).
REQ-020 out_valid SHALL be 1 in ONE and FULL.
REQ-021 Transitions: EMPTY+accept->ONE; ONE+accept+!pop->FULL; ONE+pop+!accept->EMPTY; ONE+accept+pop->ONE; FULL+pop->ONE; otherwise hold.
REQ-022 Latency SHALL be one cycle: entry accepted at edge N appears on outputs after edge N when buffer was EMPTY or simultaneously popped to EMPTY.
REQ-023 Order SHALL be FIFO; head SHALL be older entry; on FULL+pop, second entry SHALL become head next cycle.
REQ-024 When out_valid=0 all payload and ctrl outputs SHALL be zero (bubble: WB_en, mem_read, mem_write, B, SR_update inactive).
REQ-025 Head outputs SHALL remain stable while out_valid && !out_ready.
REQ-026 flush SHALL, at next edge, force EMPTY, discard both entries and any same-cycle accept; in_ready SHALL be 1 the following cycle.
REQ-027 flush SHALL take priority over accept and pop in the same cycle.
REQ-028 stall_cycles SHALL increment by 1 each cycle out_valid && !out_ready, saturate at all-ones, clear only on rst.
REQ-029 in_valid when in_ready=0 SHALL be ignored with no state change.

Reset
REQ-030 rst high at an edge SHALL force EMPTY, occupancy 0, out_valid 0, all payload/ctrl outputs 0, stall_cycles 0, overriding flush, accept, pop.
REQ-031 rst asserted mid-operation with FULL buffer SHALL discard both entries; first accept after rst deasserts SHALL behave as from EMPTY.

Structure
REQ-032 WORD_WIDTH default, control-bundle field widths and bit offsets (REG_FILE_DEPTH, SIGNED_IMM_WIDTH, SHIFTER_OPERAND_WIDTH, EX_command, status) SHALL live in the shared settings package; state encoding local.
REQ-033 One sub-module pipe_entry_reg (single enabled, clearable payload register) SHALL be instantiated twice for main and skid slots.

Verification
REQ-034 rst then in_valid=1, pc_in=0x10, out_ready=1 -> next cycle out_valid=1, pc=0x10, occupancy 1, in_ready 1.
REQ-035 out_ready=0, push 0x20,0x24,0x28 on consecutive cycles -> occupancy 2, in_ready 0, 0x28 dropped, pc held 0x20; out_ready=1 -> 0x20 then 0x24, then out_valid 0.
REQ-036 FULL, flush=1 with in_valid=1 and out_ready=1 -> next cycle occupancy 0, out_valid 0, all outputs 0, in_ready 1.
REQ-037 ONE, simultaneous accept 0x30 and pop -> occupancy stays 1, pc=0x30 next cycle.
REQ-038 CNT_WIDTH=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles reaches 15 and holds; rst -> 0.
REQ-039 FULL, rst and flush both high -> all outputs 0, stall_cycles 0, occupancy 0.

Source files
------------

// File: rtl/id_ex_skid_reg_pkg.sv
// Shared ID/EX pipeline settings: default widths and the packed control
// bundle layout carried alongside each instruction.
package id_ex_skid_reg_pkg;

  localparam int WORD_WIDTH_DEF        = 32;
  localparam int REG_FILE_DEPTH        = 16;
  localparam int REG_ADDR_WIDTH        = $clog2(REG_FILE_DEPTH);
  localparam int SIGNED_IMM_WIDTH      = 10;
  localparam int SHIFTER_OPERAND_WIDTH = 12;
  localparam int EX_CMD_WIDTH          = 4;
  localparam int STATUS_WIDTH          = 4;

  // Bit offsets inside the control bundle, LSB first
  localparam int SR_UPDATE_OFS = 0;
  localparam int B_OFS         = 1;
  localparam int IMM_OFS       = 2;
  localparam int WB_EN_OFS     = 3;
  localparam int MEM_WRITE_OFS = 4;
  localparam int MEM_READ_OFS  = 5;
  localparam int STATUS_OFS    = 6;
  localparam int EX_CMD_OFS    = STATUS_OFS + STATUS_WIDTH;
  localparam int SHIFTER_OFS   = EX_CMD_OFS + EX_CMD_WIDTH;
  localparam int SIGNED_IMM_OFS = SHIFTER_OFS + SHIFTER_OPERAND_WIDTH;
  localparam int DST_OFS       = SIGNED_IMM_OFS + SIGNED_IMM_WIDTH;

  typedef enum logic [EX_CMD_WIDTH-1:0] {
    EX_NOP = 4'd0,
    EX_MOV = 4'd1,
    EX_MVN = 4'd2,
    EX_ADD = 4'd3,
    EX_ADC = 4'd4,
    EX_SUB = 4'd5,
    EX_SBC = 4'd6,
    EX_AND = 4'd7,
    EX_ORR = 4'd8,
    EX_EOR = 4'd9,
    EX_LDR = 4'd10,
    EX_STR = 4'd11
  } ex_cmd_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0]        dst;
    logic [SIGNED_IMM_WIDTH-1:0]      signed_imm;
    logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand;
    ex_cmd_e                          ex_cmd;
    logic [STATUS_WIDTH-1:0]          status;
    logic                             mem_read;
    logic                             mem_write;
    logic                             wb_en;
    logic                             imm;
    logic                             b;
    logic                             sr_update;
  } id_ex_ctrl_t;

  localparam int CTRL_WIDTH_DEF = $bits(id_ex_ctrl_t);

  // Width of one stored entry: pc, instruction, Rn, Rm plus control bundle
  function automatic int entry_width(input int word_w, input int ctrl_w);
    return (4 * word_w) + ctrl_w;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload slot of the ID/EX skid buffer: enabled load, synchronous clear.
module pipe_entry_reg
  import id_ex_skid_reg_pkg::*;
#(
  parameter int WIDTH = entry_width(WORD_WIDTH_DEF, CTRL_WIDTH_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Slot storage; clear wins over load so a discarded entry never lingers
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (clr) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register built as a two-entry skid buffer. The main slot is
// always the head, so every EX-facing output comes straight from a flop.
module id_ex_skid_reg
  import id_ex_skid_reg_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] pc_in,
  input  logic [WORD_WIDTH-1:0] instruction_in,
  input  logic [WORD_WIDTH-1:0] val_Rn_in,
  input  logic [WORD_WIDTH-1:0] val_Rm_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic [WORD_WIDTH-1:0] val_Rn_out,
  output logic [WORD_WIDTH-1:0] val_Rm_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  localparam int ENTRY_W = entry_width(WORD_WIDTH, CTRL_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e               state_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [1:0]           occupancy_r;
  logic [CNT_WIDTH-1:0] stall_r;

  logic               accept_s;
  logic               pop_s;
  logic               main_en_s;
  logic               main_clr_s;
  logic               main_sel_skid_s;
  logic               skid_en_s;
  logic               skid_clr_s;
  logic [ENTRY_W-1:0] in_word_s;
  logic [ENTRY_W-1:0] main_d_s;
  logic [ENTRY_W-1:0] main_q_s;
  logic [ENTRY_W-1:0] skid_q_s;

  assign accept_s  = in_valid && in_ready_r;
  assign pop_s     = out_valid_r && out_ready;
  assign in_word_s = {pc_in, instruction_in, val_Rn_in, val_Rm_in, ctrl_in};
  assign main_d_s  = main_sel_skid_s ? skid_q_s : in_word_s;

  // Slot steering: which slot loads, clears or refills from the skid
  always_comb begin
    main_en_s       = 1'b0;
    main_clr_s      = 1'b0;
    main_sel_skid_s = 1'b0;
    skid_en_s       = 1'b0;
    skid_clr_s      = 1'b0;
    if (flush) begin
      main_clr_s = 1'b1;
      skid_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          main_en_s = accept_s;
        end
        ST_ONE: begin
          if (pop_s && accept_s) begin
            main_en_s = 1'b1;
          end else if (pop_s) begin
            main_clr_s = 1'b1;
          end else if (accept_s) begin
            skid_en_s = 1'b1;
          end else begin
            main_en_s = 1'b0;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            main_en_s       = 1'b1;
            main_sel_skid_s = 1'b1;
            skid_clr_s      = 1'b1;
          end else begin
            main_en_s = 1'b0;
          end
        end
        default: begin
          main_clr_s = 1'b1;
          skid_clr_s = 1'b1;
        end
      endcase
    end
  end

  pipe_entry_reg #(.WIDTH(ENTRY_W)) u_main_slot (
    .clk (clk),
    .rst (rst),
    .en  (main_en_s),
    .clr (main_clr_s),
    .d   (main_d_s),
    .q   (main_q_s)
  );

  pipe_entry_reg #(.WIDTH(ENTRY_W)) u_skid_slot (
    .clk (clk),
    .rst (rst),
    .en  (skid_en_s),
    .clr (skid_clr_s),
    .d   (in_word_s),
    .q   (skid_q_s)
  );

  // Occupancy FSM; handshake outputs are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r     <= ST_ONE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b1;
            occupancy_r <= 2'd1;
          end else begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
          end
        end
        ST_ONE: begin
          if (accept_s && !pop_s) begin
            state_r     <= ST_FULL;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            occupancy_r <= 2'd2;
          end else if (pop_s && !accept_s) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
          end else begin
            state_r     <= ST_ONE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b1;
            occupancy_r <= 2'd1;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            state_r     <= ST_ONE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b1;
            occupancy_r <= 2'd1;
          end else begin
            state_r     <= ST_FULL;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            occupancy_r <= 2'd2;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          occupancy_r <= 2'd0;
        end
      endcase
    end
  end

  // Back-pressure counter: saturates, and only reset clears it (not flush)
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= '0;
    end else if (out_valid_r && !out_ready && (stall_r != CNT_MAX)) begin
      stall_r <= stall_r + CNT_ONE;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign occupancy    = occupancy_r;
  assign stall_cycles = stall_r;
  assign {pc, instruction, val_Rn_out, val_Rm_out, ctrl_out} = main_q_s;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Randomized scoreboard bench for id_ex_skid_reg: a queue-based reference
// model tracks held entries and the saturating back-pressure count.
module tb_id_ex_skid_reg;

  localparam int W     = 32;
  localparam int CW    = 40;
  localparam int CNTW  = 4;
  localparam int EW    = 4 * W + CW;
  localparam int STMAX = (1 << CNTW) - 1;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    pc_in, instruction_in, val_Rn_in, val_Rm_in;
  logic [CW-1:0]   ctrl_in;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    pc, instruction, val_Rn_out, val_Rm_out;
  logic [CW-1:0]   ctrl_out;
  logic [1:0]      occupancy;
  logic [CNTW-1:0] stall_cycles;

  id_ex_skid_reg #(.WORD_WIDTH(W), .CTRL_WIDTH(CW), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .instruction(instruction),
    .val_Rn_out(val_Rn_out), .val_Rm_out(val_Rm_out), .ctrl_out(ctrl_out),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  logic [EW-1:0] exp_q[$];
  int stall_m = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
  endtask

  // Reference model: a plain FIFO of at most two entries plus a counter
  always @(posedge clk) begin
    int sz;
    logic [EW-1:0] w;
    sz = exp_q.size();
    w = {pc_in, instruction_in, val_Rn_in, val_Rm_in, ctrl_in};
    if (rst) begin
      exp_q.delete();
      stall_m = 0;
    end else begin
      if (sz > 0 && !out_ready && stall_m < STMAX) stall_m = stall_m + 1;
      if (flush) exp_q.delete();
      else begin
        if (sz > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && sz < 2) exp_q.push_back(w);
      end
    end
  end

  // Monitor: compare DUT outputs against the model away from the active edge
  always @(negedge clk) begin
    logic [EW-1:0] head;
    if (chk_en) begin
      head = {pc, instruction, val_Rn_out, val_Rm_out, ctrl_out};
      chk("occupancy", EW'(occupancy), EW'(exp_q.size()));
      chk("in_ready", EW'(in_ready), EW'(exp_q.size() < 2));
      chk("out_valid", EW'(out_valid), EW'(exp_q.size() > 0));
      chk("stall_cycles", EW'(stall_cycles), EW'(stall_m));
      if (exp_q.size() > 0) chk("head", head, exp_q[0]);
      else chk("bubble_zero", head, '0);
    end
  end

  task automatic step(input logic v, input logic fl, input logic rdy,
                      input logic rs, input logic [W-1:0] pcv);
    in_valid = v;
    flush = fl;
    out_ready = rdy;
    rst = rs;
    pc_in = pcv;
    instruction_in = $urandom();
    val_Rn_in = $urandom();
    val_Rm_in = $urandom();
    ctrl_in = {8'($urandom()), 32'($urandom())};
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rdy_pct;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; instruction_in = '0; val_Rn_in = '0; val_Rm_in = '0; ctrl_in = '0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_en = 1'b1;

    // Single entry, one-cycle latency
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h10);
    chk("lat_pc", EW'(pc), EW'(32'h10));
    chk("lat_occ", EW'(occupancy), EW'(2'd1));
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

    // Fill under back-pressure; third push must be dropped
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h24);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h28);
    chk("full_occ", EW'(occupancy), EW'(2'd2));
    chk("full_hold_pc", EW'(pc), EW'(32'h20));
    chk("full_in_ready", EW'(in_ready), EW'(1'b0));
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("drain_pc", EW'(pc), EW'(32'h24));
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("drain_empty", EW'(out_valid), EW'(1'b0));

    // Simultaneous accept and pop in ONE
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h2c);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h30);
    chk("thru_pc", EW'(pc), EW'(32'h30));
    chk("thru_occ", EW'(occupancy), EW'(2'd1));

    // Flush from FULL beats accept and pop
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h50);
    chk("flush_head", {pc, instruction, val_Rn_out, val_Rm_out, ctrl_out}, '0);
    chk("flush_in_ready", EW'(in_ready), EW'(1'b1));

    // Counter saturation and reset clear
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h60);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_sat", EW'(stall_cycles), EW'(4'hF));
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("stall_rst", EW'(stall_cycles), EW'(4'h0));

    // Reset and flush together on a FULL buffer
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h70);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h74);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h78);
    chk("rstflush_occ", EW'(occupancy), EW'(2'd0));
    chk("rstflush_head", {pc, instruction, val_Rn_out, val_Rm_out, ctrl_out}, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h80);
    chk("post_rst_pc", EW'(pc), EW'(32'h80));

    // Randomized phases with varying consumer readiness
    for (int ph = 0; ph < 4; ph++) begin
      rdy_pct = 20 + ph * 25;
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 149) == 0,
             $urandom());
      end
    end

    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
